// File: rtl/spio_uart_tx_merge_pkg.sv
// SpiNNaker packet layout shared by the spio_uart TX merge path and its arbiter.
// Also provides the `PKT_LEN macro for blocks that size ports from it.
`ifndef PKT_LEN
`define PKT_LEN 72
`endif

package spio_uart_tx_merge_pkg;

   localparam int unsigned PKT_LEN = `PKT_LEN;

   // Field order from MSB: payload [71:40], key [39:8], ctrl [7:2], long flag [1], parity [0]
   typedef struct packed {
      logic [31:0] payload;
      logic [31:0] key;
      logic [5:0]  ctrl;
      logic        long_pkt;
      logic        parity;
   } pkt_t;

   // Parity bit value that gives odd parity over the valid bits (40 short / 72 long)
   function automatic logic pkt_odd_parity_bit(input pkt_t p);
      logic x;
      x = ^{p.key, p.ctrl, p.long_pkt};
      if (p.long_pkt) begin
         x = x ^ (^p.payload);
      end
      return ~x;
   endfunction

endpackage

// File: rtl/spio_uart_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last granted port.
// The pointer moves to the granted port only when the advance strobe is set.
module spio_uart_rr_arb
   import spio_uart_tx_merge_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned SEL_BITS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic                 i_adv,
   output logic [NUM_PORTS-1:0] o_gnt_c,
   output logic [SEL_BITS-1:0]  o_idx_c,
   output logic                 o_any_c
);

   logic [SEL_BITS-1:0]  r_ptr;
   logic [SEL_BITS-1:0]  w_idx;
   logic [SEL_BITS-1:0]  w_cand;
   logic                 w_any;
   logic [NUM_PORTS-1:0] w_gnt;

   // Reset points at the last port so port 0 has first priority
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= SEL_BITS'(NUM_PORTS - 1);
      end else if (i_adv && w_any) begin
         r_ptr <= w_idx;
      end
   end

   always_comb begin
      w_any  = 1'b0;
      w_idx  = '0;
      w_cand = '0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         w_cand = SEL_BITS'((32'(r_ptr) + k) % NUM_PORTS);
         if (!w_any && i_req[w_cand]) begin
            w_any = 1'b1;
            w_idx = w_cand;
         end
      end
   end

   always_comb begin
      w_gnt = '0;
      if (w_any) begin
         w_gnt[w_idx] = 1'b1;
      end
   end

   assign o_gnt_c = w_gnt;
   assign o_idx_c = w_idx;
   assign o_any_c = w_any;

endmodule

// File: rtl/spio_uart_tx_merge.sv
// Round-robin merge of NUM_PORTS packet streams into one registered slot feeding spio_uart TX.
// Optional SPIO_UART_TX_MERGE_PARITY_EN: rewrite bit 0 of each accepted packet to odd parity.
module spio_uart_tx_merge
   import spio_uart_tx_merge_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned SEL_BITS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                         CLK_IN,
   input  logic                         RESET_IN,
   input  logic [NUM_PORTS*PKT_LEN-1:0] IN_DATA_IN,
   input  logic [NUM_PORTS-1:0]         IN_VLD_IN,
   output logic [NUM_PORTS-1:0]         IN_RDY_OUT,
   output logic [PKT_LEN-1:0]           OUT_DATA_OUT,
   output logic                         OUT_VLD_OUT,
   input  logic                         OUT_RDY_IN,
   output logic [SEL_BITS-1:0]          OUT_SEL_OUT
);

   logic [NUM_PORTS-1:0] w_gnt;
   logic [SEL_BITS-1:0]  w_idx;
   logic                 w_any;
   logic                 w_slot_free;
   logic                 w_in_xfer;
   pkt_t                 w_mux_pkt;
   pkt_t                 w_next_pkt;

   logic                 r_out_vld;
   pkt_t                 r_out_pkt;
   logic [SEL_BITS-1:0]  r_out_sel;

   spio_uart_rr_arb #(
      .NUM_PORTS (NUM_PORTS),
      .SEL_BITS  (SEL_BITS)
   ) u_arb (
      .i_clk   (CLK_IN),
      .i_rst   (RESET_IN),
      .i_req   (IN_VLD_IN),
      .i_adv   (w_in_xfer),
      .o_gnt_c (w_gnt),
      .o_idx_c (w_idx),
      .o_any_c (w_any)
   );

   // The slot can take a packet when empty or draining this cycle
   assign w_slot_free = !r_out_vld || OUT_RDY_IN;
   assign w_in_xfer   = w_any && w_slot_free && !RESET_IN;
   assign IN_RDY_OUT  = {NUM_PORTS{w_in_xfer}} & w_gnt & IN_VLD_IN;

   always_comb begin
      w_mux_pkt = pkt_t'(IN_DATA_IN[32'(w_idx) * PKT_LEN +: PKT_LEN]);
   end

`ifdef SPIO_UART_TX_MERGE_PARITY_EN
   always_comb begin
      w_next_pkt        = w_mux_pkt;
      w_next_pkt.parity = pkt_odd_parity_bit(w_mux_pkt);
   end
`else
   assign w_next_pkt = w_mux_pkt;
`endif

   // Output slot: refill on input transfer, empty on output-only transfer, otherwise hold
   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         r_out_vld <= 1'b0;
         r_out_pkt <= '0;
         r_out_sel <= '0;
      end else if (w_in_xfer) begin
         r_out_vld <= 1'b1;
         r_out_pkt <= w_next_pkt;
         r_out_sel <= w_idx;
      end else if (OUT_RDY_IN) begin
         r_out_vld <= 1'b0;
      end
   end

   assign OUT_DATA_OUT = r_out_pkt;
   assign OUT_VLD_OUT  = r_out_vld;
   assign OUT_SEL_OUT  = r_out_sel;

endmodule

// File: tb/tb_spio_uart_tx_merge.sv
// Bench for spio_uart_tx_merge: a 2-port and a 4-port instance checked every cycle
// against a queue-based model, plus literal expectations for the directed scenarios.
module tb_spio_uart_tx_merge;

   localparam int PL = 72;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT-facing signals, written only by the driver/checker process
   logic              rst   = 1'b1;
   logic              ordy2 = 1'b1;
   logic              ordy4 = 1'b1;
   logic [2*PL-1:0]   d2    = '0;
   logic [1:0]        v2    = '0;
   logic [4*PL-1:0]   d4    = '0;
   logic [3:0]        v4    = '0;
   logic [1:0]        r2;
   logic [3:0]        r4;
   logic [PL-1:0]     od2, od4;
   logic              ov2, ov4;
   logic [0:0]        os2;
   logic [1:0]        os4;

   // Scenario knobs written by the directing initial block
   logic              k_rst = 1'b1;
   logic              k_ordy [2] = '{1'b1, 1'b1};

   // Source queues: inst 0 uses slots 0..1, inst 1 uses slots 4..7
   logic [PL-1:0]     srcq [8][$];
   int                lkey [2][$];
   int                lsel [2][$];

   // Model state: expected contents of the output slot and last-granted port
   logic              m_vld  [2] = '{1'b0, 1'b0};
   logic [PL-1:0]     m_data [2] = '{72'd0, 72'd0};
   int                m_sel  [2] = '{0, 0};
   int                m_ptr  [2] = '{1, 3};

   int                n_vec = 0;
   int                n_err = 0;

   int                m_n, m_g, m_p, a_sel;
   logic              m_free, a_vld, a_ordy;
   logic [PL-1:0]     a_data;
   logic [3:0]        a_rdy, e_rdy;

   spio_uart_tx_merge #(.NUM_PORTS(2)) u_dut2 (
      .CLK_IN       (clk),
      .RESET_IN     (rst),
      .IN_DATA_IN   (d2),
      .IN_VLD_IN    (v2),
      .IN_RDY_OUT   (r2),
      .OUT_DATA_OUT (od2),
      .OUT_VLD_OUT  (ov2),
      .OUT_RDY_IN   (ordy2),
      .OUT_SEL_OUT  (os2)
   );

   spio_uart_tx_merge #(.NUM_PORTS(4)) u_dut4 (
      .CLK_IN       (clk),
      .RESET_IN     (rst),
      .IN_DATA_IN   (d4),
      .IN_VLD_IN    (v4),
      .IN_RDY_OUT   (r4),
      .OUT_DATA_OUT (od4),
      .OUT_VLD_OUT  (ov4),
      .OUT_RDY_IN   (ordy4),
      .OUT_SEL_OUT  (os4)
   );

   task automatic chk(input string nm, input logic [PL-1:0] act, input logic [PL-1:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   function automatic logic [PL-1:0] mk(input logic lng, input logic [31:0] key, input logic [31:0] pay);
      return {pay, key, 6'd0, lng, 1'b0};
   endfunction

   // Expected packet as it must appear at the output
   function automatic logic [PL-1:0] model_pkt(input logic [PL-1:0] p);
      logic [PL-1:0] r;
      r = p;
`ifdef SPIO_UART_TX_MERGE_PARITY_EN
      begin
         int ones;
         ones  = p[1] ? $countones(p[71:1]) : $countones(p[39:1]);
         r[0]  = ((ones % 2) == 0);
      end
`endif
      return r;
   endfunction

   function automatic bit busy(input int s);
      bit b;
      b = m_vld[s];
      for (int p = 0; p < 4; p++) begin
         if (srcq[s*4+p].size() > 0) b = 1'b1;
      end
      return b;
   endfunction

   // Drive inputs on the falling edge, then check outputs and advance the model
   always @(negedge clk) begin
      rst   = k_rst;
      ordy2 = k_ordy[0];
      ordy4 = k_ordy[1];
      for (int p = 0; p < 2; p++) begin
         v2[p] = (srcq[p].size() > 0);
         if (srcq[p].size() > 0) d2[p*PL +: PL] = srcq[p][0];
         else                    d2[p*PL +: PL] = '0;
      end
      for (int p = 0; p < 4; p++) begin
         v4[p] = (srcq[4+p].size() > 0);
         if (srcq[4+p].size() > 0) d4[p*PL +: PL] = srcq[4+p][0];
         else                      d4[p*PL +: PL] = '0;
      end
      #1;
      for (int s = 0; s < 2; s++) begin
         if (s == 0) begin
            m_n = 2; a_vld = ov2; a_data = od2; a_sel = int'(os2); a_rdy = {2'b00, r2}; a_ordy = ordy2;
         end else begin
            m_n = 4; a_vld = ov4; a_data = od4; a_sel = int'(os4); a_rdy = r4; a_ordy = ordy4;
         end
         if (a_vld && a_ordy) begin
            lkey[s].push_back(int'(a_data[39:8]));
            lsel[s].push_back(a_sel);
         end
         m_free = !m_vld[s] || a_ordy;
         m_g    = -1;
         if (!rst) begin
            for (int k = 1; k <= m_n; k++) begin
               m_p = (m_ptr[s] + k) % m_n;
               if (m_g < 0 && srcq[s*4+m_p].size() > 0) m_g = m_p;
            end
         end
         e_rdy = '0;
         if (m_free && m_g >= 0) e_rdy[m_g] = 1'b1;
         chk($sformatf("i%0d_vld", s), PL'(a_vld), PL'(m_vld[s]));
         chk($sformatf("i%0d_rdy", s), PL'(a_rdy), PL'(e_rdy));
         if (m_vld[s]) begin
            chk($sformatf("i%0d_data", s), a_data, m_data[s]);
            chk($sformatf("i%0d_sel", s), PL'(a_sel), PL'(m_sel[s]));
         end
         if (rst) begin
            m_vld[s]  = 1'b0;
            m_data[s] = '0;
            m_sel[s]  = 0;
            m_ptr[s]  = m_n - 1;
         end else if (m_free && m_g >= 0) begin
            m_vld[s]  = 1'b1;
            m_data[s] = model_pkt(srcq[s*4+m_g][0]);
            m_sel[s]  = m_g;
            m_ptr[s]  = m_g;
            void'(srcq[s*4+m_g].pop_front());
         end else if (a_ordy) begin
            m_vld[s] = 1'b0;
         end
      end
   end

   task automatic wait_idle(input int s, input int budget);
      int c;
      c = 0;
      while (busy(s) && c < budget) begin
         @(posedge clk);
         c++;
      end
      if (busy(s)) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_i%0d: still busy after %0d cycles, required idle", s, budget);
      end
      @(posedge clk);
   endtask

   task automatic pulse_rst();
      @(posedge clk);
      k_rst = 1'b1;
      @(posedge clk);
      k_rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         lkey[s].delete();
         lsel[s].delete();
      end
   endtask

   initial begin
      logic [PL-1:0] exp_short, exp_long;
      int exp_seq [9];

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      chk("rst_vld2", PL'(ov2), 72'd0);
      chk("rst_data2", od2, 72'd0);
      chk("rst_rdy2", PL'(r2), 72'd0);
      chk("rst_sel4", PL'(os4), 72'd0);
      @(posedge clk);
      k_rst = 1'b0;
      @(posedge clk);

      // Single port: keys 0..9 alternating short/long, one-cycle latency, one per cycle
      for (int k = 0; k < 10; k++) srcq[0].push_back(mk(1'(k % 2), 32'(k), 32'(k * 17)));
      @(negedge clk); #2;
      chk("lat_before", PL'(ov2), 72'd0);
      @(negedge clk); #2;
      chk("lat_vld", PL'(ov2), 72'd1);
      chk("lat_key0", PL'(od2[39:8]), 72'd0);
      chk("lat_sel0", PL'(os2), 72'd0);
      @(negedge clk); #2;
      chk("rate_key1", PL'(od2[39:8]), 72'd1);
      wait_idle(0, 50);
      chk("sp_count", PL'(lkey[0].size()), 72'd10);
      for (int i = 0; i < 10 && i < lkey[0].size(); i++) begin
         chk("sp_key", PL'(lkey[0][i]), PL'(i));
         chk("sp_sel", PL'(lsel[0][i]), 72'd0);
      end

      // Fairness with a 20-cycle backpressure window mid-stream
      pulse_rst();
      for (int k = 0; k < 8; k++) begin
         srcq[0].push_back(mk(1'b0, 32'(k), 32'd0));
         srcq[1].push_back(mk(1'b1, 32'(256 + k), 32'(k)));
      end
      repeat (6) @(posedge clk);
      k_ordy[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      chk("bp_rdy", PL'(r2), 72'd0);
      chk("bp_vld", PL'(ov2), 72'd1);
      repeat (17) @(posedge clk);
      k_ordy[0] = 1'b1;
      wait_idle(0, 100);
      chk("fair_count", PL'(lsel[0].size()), 72'd16);
      for (int i = 0; i < 16 && i < lsel[0].size(); i++) begin
         chk("fair_sel", PL'(lsel[0][i]), PL'(i % 2));
         chk("fair_key", PL'(lkey[0][i]), PL'((i % 2) * 256 + i / 2));
      end

      // Four ports, sparse requests on 3 and 1, then a wrap through port 0
      pulse_rst();
      for (int k = 0; k < 3; k++) begin
         srcq[7].push_back(mk(1'b0, 32'(768 + k), 32'd0));
         srcq[5].push_back(mk(1'b1, 32'(256 + k), 32'hA5));
      end
      wait_idle(1, 50);
      srcq[4].push_back(mk(1'b0, 32'h400, 32'd0));
      srcq[6].push_back(mk(1'b0, 32'h402, 32'd0));
      srcq[7].push_back(mk(1'b0, 32'h403, 32'd0));
      wait_idle(1, 50);
      exp_seq = '{1, 3, 1, 3, 1, 3, 0, 2, 3};
      chk("sparse_count", PL'(lsel[1].size()), 72'd9);
      for (int i = 0; i < 9 && i < lsel[1].size(); i++) begin
         chk("sparse_sel", PL'(lsel[1][i]), PL'(exp_seq[i]));
      end
      if (lkey[1].size() > 1) begin
         chk("sparse_key0", PL'(lkey[1][0]), 72'h100);
         chk("sparse_key1", PL'(lkey[1][1]), 72'h300);
      end

      // Reset while the slot holds a packet
      @(posedge clk);
      k_ordy[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         srcq[0].push_back(mk(1'b0, 32'(16 + k), 32'd0));
         srcq[1].push_back(mk(1'b0, 32'(32 + k), 32'd0));
      end
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      chk("pre_rst_vld", PL'(ov2), 72'd1);
      @(posedge clk);
      k_rst = 1'b1;
      @(posedge clk);
      k_rst = 1'b0;
      @(negedge clk); #2;
      chk("post_rst_vld", PL'(ov2), 72'd0);
      chk("post_rst_data", od2, 72'd0);
      @(negedge clk); #2;
      chk("post_rst_vld1", PL'(ov2), 72'd1);
      chk("post_rst_sel", PL'(os2), 72'd0);
      chk("post_rst_key", PL'(od2[39:8]), 72'h11);
      @(posedge clk);
      k_ordy[0] = 1'b1;
      wait_idle(0, 50);

      // Parity vectors
`ifdef SPIO_UART_TX_MERGE_PARITY_EN
      exp_short = {32'h0, 32'h3, 8'h01};
      exp_long  = {32'h5, 32'h5, 8'h02};
`else
      exp_short = {32'h0, 32'h3, 8'h00};
      exp_long  = {32'h5, 32'h5, 8'h03};
`endif
      srcq[0].push_back({32'h0, 32'h3, 8'h00});
      srcq[0].push_back({32'h5, 32'h5, 8'h03});
      @(negedge clk); #2;
      @(negedge clk); #2;
      chk("par_short", od2, exp_short);
      @(negedge clk); #2;
      chk("par_long", od2, exp_long);
      wait_idle(0, 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/spio_uart_tx_merge.md
Name: spio_uart_tx_merge

Overview:
- Round-robin merger of NUM_PORTS SpiNNaker packet streams into the single TX packet input of spio_uart.
- Sits directly upstream of spio_uart's TX_DATA_IN/TX_VLD_IN/TX_RDY_OUT port.
- Uses one registered output slot and sustains one packet per cycle when downstream is ready.
- Strictly fair: no input is starved while it holds valid.

Parameters:
- NUM_PORTS, 2, number of input streams (2..8).
- SEL_BITS, $clog2(NUM_PORTS) (minimum 1), width of the source index.

Ports:
- CLK_IN  in  1  clock.
- RESET_IN  in  1  synchronous, active-high reset, sampled on the rising edge of CLK_IN.
- IN_DATA_IN  in  NUM_PORTS*`PKT_LEN  input packets; port i occupies bits [i*`PKT_LEN +: `PKT_LEN].
- IN_VLD_IN  in  NUM_PORTS  per-port valid.
- IN_RDY_OUT  out  NUM_PORTS  per-port ready.
- OUT_DATA_OUT  out  `PKT_LEN  merged packet, connected to spio_uart TX_DATA_IN.
- OUT_VLD_OUT  out  1  output valid.
- OUT_RDY_IN  in  1  output ready, from spio_uart TX_RDY_OUT.
- OUT_SEL_OUT  out  SEL_BITS  index of the port that supplied OUT_DATA_OUT.

Behaviour:
- Packet format: bit 0 is parity; bit 1 set means long packet (72 valid bits), clear means short packet (40 valid bits, bits 71:40 don't-care). Data passes through unmodified unless the optional feature below is enabled.
- Transfer rules:
  - A transfer on any interface occurs when valid && ready at a rising edge.
  - Valid must not depend on ready.
  - A source must hold data and valid stable until accepted; a bench breaking this is out of contract.
- slot_free = !OUT_VLD_OUT || OUT_RDY_IN (combinational).
- Arbitration:
  - Register ptr holds the last granted port.
  - grant = first port with IN_VLD_IN set, searching ptr+1, ptr+2, … modulo NUM_PORTS.
  - IN_RDY_OUT[i] = slot_free && (grant == i) && IN_VLD_IN[i].
  - At most one IN_RDY_OUT bit is high.
- On an input transfer from port g:
  - OUT_DATA_OUT <= packet g, OUT_SEL_OUT <= g, OUT_VLD_OUT <= 1, ptr <= g.
  - Latency is 1 cycle from input transfer to OUT_VLD_OUT.
- On an output transfer with no input transfer in the same cycle: OUT_VLD_OUT <= 0.
- Output transfer and input transfer in the same cycle: the slot is refilled, OUT_VLD_OUT stays 1, throughput is 1 packet/cycle.
- OUT_VLD_OUT=1 and OUT_RDY_IN=0: output registers hold, all IN_RDY_OUT=0, ptr holds.
- No IN_VLD_IN set: ptr holds, no grant.
- ptr wrap: ptr=NUM_PORTS-1 searches from port 0.
- Reset values: OUT_VLD_OUT=0, OUT_DATA_OUT=0, OUT_SEL_OUT=0, ptr=NUM_PORTS-1 (port 0 has first priority), IN_RDY_OUT=0 while RESET_IN is high.
- Reset mid-operation: a held output packet is discarded; no partial state survives.

Optional Feature:
- Macro: SPIO_UART_TX_MERGE_PARITY_EN.
- Defined: the block recomputes bit 0 of each accepted packet so the packet's valid bits (40 short / 72 long) have odd parity. The corrected value is registered into OUT_DATA_OUT; latency is unchanged. Added logic is one XOR tree on the input-mux output.
- Undefined: bit 0 passes through unmodified, and spio_uart's own parity filter drops bad packets.

Decomposition:
- Shared package/header spio_uart_common.h supplies:
  - `PKT_LEN (72);
  - header field positions: parity bit 0, long-packet flag bit 1, key [39:8], payload [71:40];
  - the short and long valid-bit counts (40, 72).
- Sub-module spio_uart_rr_arb holds ptr and the rotate/priority-encode logic.
  - Inputs: request vector, advance strobe.
  - Outputs: one-hot grant, grant index.
  - Reusable by later RX-side demux/merge blocks.

Test Plan:
- Single port: NUM_PORTS=2, port 0 streams keys 0..9 alternating short/long, OUT_RDY_IN=1 -> 10 packets out in order, OUT_SEL_OUT=0, first OUT_VLD_OUT one cycle after first transfer, 1 packet/cycle.
- Fairness: both ports continuously valid (port 0 keys 0x000.., port 1 keys 0x100..), OUT_RDY_IN=1 -> OUT_SEL_OUT alternates 0,1,0,1 starting at 0 after reset; each port's keys stay in ascending order.
- Backpressure: OUT_RDY_IN=0 for 20 cycles mid-stream -> OUT_DATA_OUT, OUT_VLD_OUT and OUT_SEL_OUT stable, IN_RDY_OUT=0; on release, no packet is lost or duplicated and alternation resumes from the held ptr.
- Wrap and sparse requests: NUM_PORTS=4, only ports 3 and 1 valid -> grant order 1,3,1,3; after port 3, search wraps through 0.
- Reset mid-stream: RESET_IN high for 1 cycle while OUT_VLD_OUT=1 -> next cycle OUT_VLD_OUT=0, OUT_DATA_OUT=0; port 0 granted first afterwards.
- Parity feature: with SPIO_UART_TX_MERGE_PARITY_EN defined, short packet key 0x00000003 with bit 0=0 -> output bit 0=1; long packet key=payload=0x5, header 0x03 -> output header 0x02. Without the macro, both packets emerge unchanged.
